// File: rtl/cbd_prescale_ctr_if.sv
// Control/status bundle of the CBD-family prescaler.
// EN, CAI, LD, D and ONESHOT flow from the controlling logic into the counter.
// Q, CAO and BUSY flow back out of it.
// The controller uses the master modport and the counter uses the slave modport.
interface cbd_prescale_ctr_if #(
  parameter int WIDTH = 8
);
  logic             EN;       // count enable
  logic             CAI;      // carry-in
  logic             LD;       // load/start strobe
  logic [WIDTH-1:0] D;        // reload value
  logic             ONESHOT;  // mode select, captured on LD
  logic [WIDTH-1:0] Q;        // current count
  logic             CAO;      // carry-out, combinational
  logic             BUSY;     // counter is running

  modport master (
    output EN, CAI, LD, D, ONESHOT,
    input  Q, CAO, BUSY
  );

  modport slave (
    input  EN, CAI, LD, D, ONESHOT,
    output Q, CAO, BUSY
  );
endinterface

// File: rtl/cbd_prescale_ctr.sv
// Loadable, cascadable down-counter prescaler for the CBD slice chain.
// CAO feeds the CAI input of the first downstream 1-bit slice.
// In continuous mode it pulses once every (reload+1) qualified carry-in cycles.
// In one-shot mode it pulses once and then returns to idle.
// Ports:
//   CLK  rising-edge clock
//   CD   synchronous active-high reset
//   bus  slave side of cbd_prescale_ctr_if:
//          EN, CAI, LD, D, ONESHOT are inputs
//          Q, CAO, BUSY are outputs
module cbd_prescale_ctr #(
  parameter int WIDTH = 8
) (
  input logic                CLK,
  input logic                CD,
  cbd_prescale_ctr_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rld;
  logic             os;
  logic             tick;
  logic             running;

  // The next count after a qualified cycle.
  // A zero count wraps to the reload value.
  // The one-shot stop is handled by the state logic, not here.
  // The decrement therefore never underflows.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] reload
  );
    if (cur == '0) next_count = reload;
    else           next_count = cur - 1'b1;
  endfunction

  // Any encoding other than RUN is treated as IDLE.
  assign running = (state == RUN);

  // LD and CD both suppress the tick.
  // As a result, a load or reset never emits a carry in the same cycle.
  assign tick    = running && bus.EN && bus.CAI && !bus.LD && !CD;

  assign bus.CAO  = tick && (q == '0);
  assign bus.Q    = q;
  assign bus.BUSY = running;

  always_ff @(posedge CLK) begin
    if (CD) begin
      q     <= '0;
      rld   <= '0;
      os    <= 1'b0;
      state <= IDLE;
    end else if (bus.LD) begin
      q     <= bus.D;
      rld   <= bus.D;
      os    <= bus.ONESHOT;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            if (q == '0 && os) begin
              // One-shot terminal count: keep Q at zero and stop.
              state <= IDLE;
            end else begin
              q <= next_count(q, rld);
            end
          end
        end
        default: begin
          // IDLE holds the last count. Only LD leaves this state.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbd_prescale_ctr.sv
module tb_cbd_prescale_ctr;
  localparam int W = 8;

  logic clk = 1'b0;
  logic cd;

  cbd_prescale_ctr_if #(.WIDTH(W)) ifc ();

  cbd_prescale_ctr #(.WIDTH(W)) dut (
    .CLK (clk),
    .CD  (cd),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         cao;
    logic         busy;
    int unsigned  cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int unsigned cycle_no = 0;

  // Reference model state.
  // m_phase counts the qualified ticks remaining until the carry.
  int unsigned m_phase;
  int unsigned m_reload;
  bit          m_oneshot;
  bit          m_active;

  // Apply the rules for the inputs that were sampled at the edge that just occurred.
  task automatic model_edge();
    if (cd) begin
      m_phase = 0; m_reload = 0; m_oneshot = 0; m_active = 0;
    end else if (ifc.LD) begin
      m_phase   = int'(ifc.D);
      m_reload  = int'(ifc.D);
      m_oneshot = ifc.ONESHOT;
      m_active  = 1;
    end else if (m_active && ifc.EN && ifc.CAI) begin
      if (m_phase == 0) begin
        if (m_oneshot) m_active = 0;
        else           m_phase  = m_reload;
      end else begin
        m_phase = m_phase - 1;
      end
    end
  endtask

  task automatic cyc(input bit c, input bit e, input bit ci, input bit l,
                     input logic [W-1:0] d, input bit o);
    exp_t ex;
    @(posedge clk);
    model_edge();
    #1;
    cycle_no++;
    cd          = c;
    ifc.EN      = e;
    ifc.CAI     = ci;
    ifc.LD      = l;
    ifc.D       = d;
    ifc.ONESHOT = o;
    ex.q    = W'(m_phase);
    ex.busy = m_active;
    ex.cao  = m_active && e && ci && !l && !c && (m_phase == 0);
    ex.cyc  = cycle_no;
    sb.push_back(ex);
  endtask

  // Monitor: pops the expected values and compares them with the DUT outputs, away from the active clock edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t ex;
      ex = sb.pop_front();
      checks++;
      if (ifc.Q !== ex.q) begin
        errors++;
        $display("FAIL q cyc=%0d got=%0d want=%0d", ex.cyc, ifc.Q, ex.q);
      end
      checks++;
      if (ifc.CAO !== ex.cao) begin
        errors++;
        $display("FAIL cao cyc=%0d got=%b want=%b", ex.cyc, ifc.CAO, ex.cao);
      end
      checks++;
      if (ifc.BUSY !== ex.busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", ex.cyc, ifc.BUSY, ex.busy);
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout got=running want=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    m_phase = 0; m_reload = 0; m_oneshot = 0; m_active = 0;
    cd = 1'b1; ifc.EN = 1'b0; ifc.CAI = 1'b0; ifc.LD = 1'b1;
    ifc.D = 8'h55; ifc.ONESHOT = 1'b0;

    // Reset with a load request pending
    cyc(1, 0, 0, 1, 8'h55, 0);
    cyc(1, 0, 0, 1, 8'h55, 0);
    cyc(0, 1, 1, 0, 8'h00, 0);   // idle after reset: no CAO

    // Continuous mode, D=3
    cyc(0, 0, 0, 1, 8'd3, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 8'd0, 0);

    // One-shot mode, D=2, then 10 idle cycles
    cyc(0, 0, 0, 1, 8'd2, 1);
    for (int i = 0; i < 13; i++) cyc(0, 1, 1, 0, 8'd0, 0);

    // Gating with CAI toggling and an EN=0 window
    cyc(0, 0, 0, 1, 8'd4, 0);
    for (int i = 0; i < 24; i++)
      cyc(0, !(i >= 6 && i < 9), (i % 2) == 0, 0, 8'd0, 0);

    // D=0: carry on every tick
    cyc(0, 0, 0, 1, 8'd0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 8'd0, 0);

    // D=FF: maximum ratio, then reload
    cyc(0, 0, 0, 1, 8'hFF, 0);
    for (int i = 0; i < 260; i++) cyc(0, 1, 1, 0, 8'd0, 0);

    // LD colliding with a terminal count
    cyc(0, 0, 0, 1, 8'd1, 0);
    cyc(0, 1, 1, 0, 8'd0, 0);    // Q=1 -> 0
    cyc(0, 1, 1, 1, 8'd7, 0);    // Q=0, tick conditions hold but LD wins
    cyc(0, 1, 1, 0, 8'd0, 0);    // Q=7

    // CD together with LD at Q=5
    cyc(0, 0, 0, 1, 8'd9, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 8'd0, 0);
    cyc(1, 1, 1, 1, 8'd9, 1);    // Q=5 here
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 8'd0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit rc, rl;
      logic [W-1:0] rd;
      rc = ($urandom_range(0, 49) == 0);
      rl = ($urandom_range(0, 14) == 0);
      rd = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      cyc(rc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rl, rd,
          $urandom_range(0, 2) == 0);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cbd_prescale_ctr.md
Name: cbd_prescale_ctr

Overview:
- Loadable, cascadable WIDTH-bit down-counter prescaler with auto-reload and one-shot modes.
- Sits directly upstream of the 1-bit down-counter slice chain (CBD-family).
- Its CAO output drives the CAI input of the first downstream slice.
- Produces one carry pulse every (reload+1) enabled carry-in cycles.

Parameters:
WIDTH, 8, counter and reload width in bits (legal 2..16)

Ports:
CLK      input   1      rising-edge clock
CD       input   1      reset; synchronous, active-high
EN       input   1      count enable
CAI      input   1      carry-in; counting qualified by CAI && EN
LD       input   1      synchronous load/start strobe
D        input   WIDTH  reload value, sampled when LD=1
ONESHOT  input   1      mode select, sampled when LD=1 (1 = one-shot, 0 = continuous)
Q        output  WIDTH  current count
CAO      output  1      carry-out to downstream CAI; combinational
BUSY     output  1      high while state = RUN

Behaviour:
- Internal registers:
  - Q (count)
  - RLD (reload value, WIDTH bits)
  - OS (latched mode)
  - state: IDLE or RUN.
- Priority at each CLK rising edge: CD > LD > count.
- CD=1:
  - Q=0, RLD=0, OS=0, state=IDLE.
  - BUSY=0 from the next cycle; CAO=0 while CD=1.
  - Overrides a simultaneous LD or count.
- LD=1 (CD=0), in either state:
  - Q<=D, RLD<=D, OS<=ONESHOT, state<=RUN.
  - Any count in progress is abandoned.
  - CAO forced 0 in the LD cycle.
- Define TICK = (state==RUN) && EN && CAI && !LD && !CD.
- CAO = TICK && (Q==0).
  - Combinational, zero latency, same cycle as the terminal count.
  - Never asserted in IDLE.
- RUN, TICK=1, Q!=0: Q<=Q-1.
- RUN, TICK=1, Q==0:
  - OS=0: Q<=RLD; stay in RUN.
  - OS=1: Q stays 0; state<=IDLE.
- RUN, TICK=0: Q holds. EN=0 or CAI=0 freezes the count with no loss of phase.
- IDLE:
  - Q holds its last value.
  - CAO=0, BUSY=0.
  - Only LD leaves IDLE.
- Division ratio:
  - Continuous mode gives one CAO per (RLD+1) TICK-qualified cycles.
  - RLD=0: CAO on every TICK cycle.
  - RLD=2^WIDTH-1: maximum ratio, 2^WIDTH.
- Arithmetic and state encoding:
  - Decrement is modulo 2^WIDTH but never underflows, since Q==0 always reloads or stops.
  - No X/illegal states: the state register decodes any non-RUN value as IDLE.
- Reset mid-operation discards RLD. After reset, LD is required before any CAO.
- After power-up, before the first CD, outputs are undefined. Bench must apply CD for at least 1 cycle.

Test Plan:
1. Reset: hold CD=1 for 2 cycles with LD=1, D=8'h55 -> Q=0, BUSY=0, CAO=0; LD ignored.
2. Continuous: LD with D=3, ONESHOT=0, then EN=CAI=1 -> Q sequence 3,2,1,0,3,2,1,0; CAO=1 exactly in the Q=0 cycles (every 4th); BUSY stays 1.
3. One-shot: LD with D=2, ONESHOT=1, EN=CAI=1 -> Q=2,1,0; CAO=1 for one cycle; then BUSY=0, Q holds 0, and CAO stays 0 for 10 further cycles.
4. Gating: continuous D=4, with CAI toggling 1,0,1,0 and EN=0 for 3 cycles -> Q decrements only on EN&&CAI cycles; CAO spacing equals 5 qualified cycles.
5. Boundaries:
   - D=0 continuous -> CAO=1 every TICK cycle.
   - D=8'hFF -> first CAO after 256 TICKs, then Q reloads to 8'hFF.
6. Collisions:
   - LD with D=7 asserted while Q==0 and TICK conditions hold -> CAO=0 that cycle; Q=7 next.
   - CD asserted at Q=5 together with LD -> Q=0, state IDLE.
